// File: rtl/text_fill_ctrl.sv
// ---------------------------------------------------------------------------
// text_fill_ctrl
//   Full-screen fill sequencer for the XGA text character buffer. After a
//   start request it walks every cell in row-major order and writes either the
//   current character_gen glyph (random mode) or a fixed blank glyph (clear
//   mode) into the char-RAM. Writes only happen while vblank is high; when
//   vblank drops mid-fill the walk parks and resumes on the next frame.
//
// Ports
//   clk       system clock
//   reset     synchronous, active-high reset
//   start     begin a fill (only honoured while idle)
//   mode      0 = clear with blank_char, 1 = random from gen_char (latched at start)
//   vblank    vertical blanking level
//   gen_char  current character_gen output
//   gen_en    combinational: step character_gen this cycle
//   wr_en     registered char-RAM write strobe
//   wr_addr   registered cell address (row*cols + col)
//   wr_data   registered glyph code
//   busy      registered: fill in progress (through the done cycle)
//   done      registered one-cycle completion pulse, coincident with last write
// ---------------------------------------------------------------------------
module text_fill_ctrl #(
    parameter int                    char_width = 8,
    parameter int                    cols       = 128,
    parameter int                    rows       = 48,
    parameter logic [char_width-1:0] blank_char = 8'h20,
    localparam int                   cells      = cols * rows,
    localparam int                   addr_width = (cells > 1) ? $clog2(cells) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  vblank,
    input  logic [char_width-1:0] gen_char,
    output logic                  gen_en,
    output logic                  wr_en,
    output logic [addr_width-1:0] wr_addr,
    output logic [char_width-1:0] wr_data,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FILL,
        S_DONE
    } state_t;

    localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(cells - 1);
    localparam logic [addr_width-1:0] ADDR_ONE  = addr_width'(1);

    state_t                state;
    logic [addr_width-1:0] addr;     // next cell to write
    logic                  mode_q;   // mode captured at start

    // One generator step per random-mode write: the glyph sampled into
    // wr_data on this edge is consumed, so character_gen advances with it.
    // Reset masks it so a fill cut short never steps the generator.
    assign gen_en = (state == S_FILL) & vblank & mode_q & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            addr    <= '0;
            mode_q  <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    wr_en <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        mode_q <= mode;
                        addr   <= '0;
                        busy   <= 1'b1;
                        state  <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    wr_en <= 1'b0;
                    if (vblank) begin
                        state <= S_FILL;
                    end
                end

                S_FILL: begin
                    if (vblank) begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr;
                        wr_data <= mode_q ? gen_char : blank_char;
                        if (addr == LAST_ADDR) begin
                            // addr parks on the last cell rather than wrapping
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            addr <= addr + ADDR_ONE;
                        end
                    end else begin
                        // blanking ended mid-fill: hold position, wait a frame
                        wr_en <= 1'b0;
                        state <= S_WAIT;
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    wr_en <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    wr_en <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_fill_ctrl.sv
module tb_text_fill_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       mode;
    logic       vblank;
    logic [7:0] gen_char;
    logic       gen_en;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;

    logic [7:0] gen_cnt;
    logic [7:0] rnd_char;
    logic       use_cnt;
    logic       gen_clr;
    int         gen_hi;

    int nvec;
    int nfail;
    int wa_q[$];
    int wd_q[$];
    int wc_q[$];
    logic busy_n1;

    text_fill_ctrl #(
        .char_width(8),
        .cols      (4),
        .rows      (2),
        .blank_char(8'h20)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .vblank  (vblank),
        .gen_char(gen_char),
        .gen_en  (gen_en),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // character_gen stand-in: free counter advanced by gen_en
    assign gen_char = use_cnt ? gen_cnt : rnd_char;

    always @(posedge clk) begin
        if (gen_clr) begin
            gen_cnt <= 8'd0;
            gen_hi  <= 0;
        end else if (gen_en) begin
            gen_cnt <= gen_cnt + 8'd1;
            gen_hi  <= gen_hi + 1;
        end
    end

    // Inputs change and outputs are sampled on negedges only.
    task automatic run_fill(input bit md, input int pause_at, input int poke_at,
                            input int rst_at, output bit tmo, output int done_c);
        int  lowc;
        bit  paused;
        bit  poked;
        lowc   = 0;
        paused = 0;
        poked  = 0;
        done_c = -1;
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        @(negedge clk);
        gen_clr = 1'b1;
        mode    = md;
        vblank  = 1'b1;
        start   = 1'b0;
        @(negedge clk);
        gen_clr = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        busy_n1 = busy;
        start   = 1'b0;
        tmo     = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (wr_en) begin
                wa_q.push_back(int'(wr_addr));
                wd_q.push_back(int'(wr_data));
                wc_q.push_back(c);
            end
            if (done) begin
                tmo    = 1'b0;
                done_c = c;
                break;
            end
            if (rst_at >= 0 && wa_q.size() == rst_at) begin
                reset = 1'b1;
                tmo   = 1'b0;
                break;
            end
            if (poke_at >= 0 && wa_q.size() == poke_at && !poked) begin
                start = 1'b1;
                mode  = ~mode;
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (lowc > 0) begin
                lowc--;
                if (lowc == 0) vblank = 1'b1;
            end else if (pause_at >= 0 && wa_q.size() == pause_at && !paused) begin
                vblank = 1'b0;
                lowc   = 5;
                paused = 1'b1;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        use_cnt = 1'b0;
        gen_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start    = 1'($urandom_range(0, 1));
            mode     = 1'($urandom_range(0, 1));
            vblank   = 1'($urandom_range(0, 1));
            rnd_char = 8'($urandom_range(0, 255));
            @(negedge clk);
            nvec++;
            if ({wr_en, wr_addr, wr_data, busy, done, gen_en} !== 15'd0) begin
                nfail++;
                $display("FAIL reset_outs cyc%0d: got en=%b a=%h d=%h busy=%b done=%b gen=%b, want all 0",
                         i, wr_en, wr_addr, wr_data, busy, done, gen_en);
            end
        end
        start  = 1'b0;
        vblank = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nvec++;
        if ({busy, wr_en, gen_en} !== 3'b000) begin
            nfail++;
            $display("FAIL reset_idle: got busy=%b wr_en=%b gen_en=%b, want 0", busy, wr_en, gen_en);
        end
    endtask

    task automatic test_clear_fill();
        bit tmo;
        int dc;
        run_fill(1'b0, -1, -1, -1, tmo, dc);
        nvec++;
        if (tmo !== 1'b0) begin nfail++; $display("FAIL clear_timeout: got no done, want done"); end
        nvec++;
        if (busy_n1 !== 1'b1) begin nfail++; $display("FAIL clear_busy_start: got %b want 1", busy_n1); end
        nvec++;
        if (wa_q.size() != 8) begin
            nfail++;
            $display("FAIL clear_count: got %0d writes want 8", wa_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                nvec++;
                if (wa_q[i] != i || wd_q[i] != 32'h20) begin
                    nfail++;
                    $display("FAIL clear_wr%0d: got a=%0d d=%h want a=%0d d=20", i, wa_q[i], wd_q[i], i);
                end
            end
            nvec++;
            if (wc_q[0] != 1) begin nfail++; $display("FAIL clear_latency: got first write cyc %0d want 1", wc_q[0]); end
            nvec++;
            if (wc_q[7] - wc_q[0] != 7) begin nfail++; $display("FAIL clear_consec: got span %0d want 7", wc_q[7] - wc_q[0]); end
            nvec++;
            if (dc != wc_q[7]) begin nfail++; $display("FAIL clear_done_align: got done cyc %0d want %0d", dc, wc_q[7]); end
        end
        nvec++;
        if (busy !== 1'b1) begin nfail++; $display("FAIL clear_busy_done: got %b want 1", busy); end
        nvec++;
        if (gen_hi != 0) begin nfail++; $display("FAIL clear_gen_en: got %0d steps want 0", gen_hi); end
        @(negedge clk);
        nvec++;
        if ({busy, done, wr_en} !== 3'b000) begin
            nfail++;
            $display("FAIL clear_after: got busy=%b done=%b wr_en=%b want 000", busy, done, wr_en);
        end
    endtask

    task automatic test_vblank_pause();
        bit tmo;
        int dc;
        run_fill(1'b0, 3, -1, -1, tmo, dc);
        nvec++;
        if (tmo !== 1'b0) begin nfail++; $display("FAIL pause_timeout: got no done, want done"); end
        nvec++;
        if (wa_q.size() != 8) begin
            nfail++;
            $display("FAIL pause_count: got %0d writes want 8", wa_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                nvec++;
                if (wa_q[i] != i) begin
                    nfail++;
                    $display("FAIL pause_addr%0d: got %0d want %0d", i, wa_q[i], i);
                end
            end
            nvec++;
            if (wc_q[3] != 10) begin nfail++; $display("FAIL pause_resume_cyc: got %0d want 10", wc_q[3]); end
            nvec++;
            if (dc != 14) begin nfail++; $display("FAIL pause_done_cyc: got %0d want 14", dc); end
        end
        vblank = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random_fill();
        bit tmo;
        int dc;
        use_cnt = 1'b1;
        run_fill(1'b1, -1, -1, -1, tmo, dc);
        nvec++;
        if (tmo !== 1'b0) begin nfail++; $display("FAIL rand_timeout: got no done, want done"); end
        nvec++;
        if (wd_q.size() != 8) begin
            nfail++;
            $display("FAIL rand_count: got %0d writes want 8", wd_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                nvec++;
                if (wd_q[i] != i || wa_q[i] != i) begin
                    nfail++;
                    $display("FAIL rand_wr%0d: got a=%0d d=%0d want a=%0d d=%0d", i, wa_q[i], wd_q[i], i, i);
                end
            end
        end
        nvec++;
        if (gen_hi != 8) begin nfail++; $display("FAIL rand_gen_steps: got %0d want 8", gen_hi); end
        @(negedge clk);
        nvec++;
        if (gen_hi != 8) begin nfail++; $display("FAIL rand_gen_after: got %0d want 8", gen_hi); end
        use_cnt = 1'b0;
    endtask

    task automatic test_start_ignored();
        bit tmo;
        int dc;
        use_cnt = 1'b1;
        run_fill(1'b0, -1, 4, -1, tmo, dc);
        nvec++;
        if (tmo !== 1'b0) begin nfail++; $display("FAIL ign_timeout: got no done, want done"); end
        nvec++;
        if (wa_q.size() != 8) begin
            nfail++;
            $display("FAIL ign_count: got %0d writes want 8", wa_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                nvec++;
                if (wa_q[i] != i || wd_q[i] != 32'h20) begin
                    nfail++;
                    $display("FAIL ign_wr%0d: got a=%0d d=%h want a=%0d d=20", i, wa_q[i], wd_q[i], i);
                end
            end
        end
        nvec++;
        if (gen_hi != 0) begin nfail++; $display("FAIL ign_gen_en: got %0d steps want 0", gen_hi); end
        // start pulse while in DONE
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nvec++;
        if ({busy, wr_en} !== 2'b00) begin nfail++; $display("FAIL ign_done_start: got busy=%b wr_en=%b want 00", busy, wr_en); end
        @(negedge clk);
        @(negedge clk);
        nvec++;
        if ({busy, wr_en} !== 2'b00) begin nfail++; $display("FAIL ign_done_later: got busy=%b wr_en=%b want 00", busy, wr_en); end
        use_cnt = 1'b0;
    endtask

    task automatic test_reset_midfill();
        bit tmo;
        int dc;
        run_fill(1'b0, -1, -1, 4, tmo, dc);
        nvec++;
        if (wa_q.size() != 4 || wa_q[3] != 3) begin
            nfail++;
            $display("FAIL midrst_pre: got %0d writes, want 4 ending at addr 3", wa_q.size());
        end
        @(negedge clk);
        nvec++;
        if ({wr_en, busy, done, gen_en} !== 4'b0000) begin
            nfail++;
            $display("FAIL midrst_outs: got wr_en=%b busy=%b done=%b gen_en=%b want 0000", wr_en, busy, done, gen_en);
        end
        reset = 1'b0;
        @(negedge clk);
        nvec++;
        if ({wr_en, busy} !== 2'b00) begin nfail++; $display("FAIL midrst_idle: got wr_en=%b busy=%b want 00", wr_en, busy); end
        run_fill(1'b0, -1, -1, -1, tmo, dc);
        nvec++;
        if (tmo !== 1'b0) begin nfail++; $display("FAIL midrst_timeout: got no done, want done"); end
        nvec++;
        if (wa_q.size() != 8) begin
            nfail++;
            $display("FAIL midrst_count: got %0d writes want 8", wa_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                nvec++;
                if (wa_q[i] != i) begin
                    nfail++;
                    $display("FAIL midrst_addr%0d: got %0d want %0d", i, wa_q[i], i);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        nvec     = 0;
        nfail    = 0;
        reset    = 1'b1;
        start    = 1'b0;
        mode     = 1'b0;
        vblank   = 1'b0;
        rnd_char = 8'h00;
        use_cnt  = 1'b0;
        gen_clr  = 1'b0;
        test_reset();
        test_clear_fill();
        test_vblank_pause();
        test_random_fill();
        test_start_ignored();
        test_reset_midfill();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
